// File: rtl/affine_pkg.sv
// Shared defaults and FSM state type for the affine/activation pipeline.
package affine_pkg;

    localparam int DATA_W_DEF  = 9;
    localparam int OUT_W_DEF   = 7;
    localparam int NUM_OUT_DEF = 32;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/relu_collect_sat.sv
// relu_sat: combinational ReLU with saturation of a signed sum to an unsigned activation.
module relu_sat
    import affine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [DATA_W-1:0] data_in,
    output logic [OUT_W-1:0]  act
);

    localparam logic [DATA_W-1:0] MAX_ACT = DATA_W'((1 << OUT_W) - 1);

    // Sign bit wins; the magnitude compare is only meaningful for non-negative inputs.
    always_comb begin
        act = data_in[OUT_W-1:0];
        if (data_in[DATA_W-1]) begin
            act = '0;
        end else if (data_in > MAX_ACT) begin
            act = '1;
        end
    end

endmodule

// File: rtl/relu_collect.sv
// relu_collect: clips neuron sums and gathers NUM_OUT of them into one output vector.
// Optional saturation counter enabled by defining SAT_CNT_EN.
module relu_collect
    import affine_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [NUM_OUT*OUT_W-1:0] out_data,
    input  logic                     out_ready
`ifdef SAT_CNT_EN
    ,
    output logic [$clog2(NUM_OUT+1)-1:0] sat_count
`endif
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               vec_release;
    logic [OUT_W-1:0]   act;
    logic [IDX_W-1:0]   idx;
    logic [OUT_W-1:0]   vec_mem [NUM_OUT];

    assign accept      = in_valid & in_ready;
    assign vec_release = out_valid & out_ready;

    relu_sat #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_relu_sat (
        .data_in (data_in),
        .act     (act)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL: if (accept && idx == LAST_IDX) next_state = HOLD;
            HOLD: if (out_ready) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == HOLD);
    end

    // The index parks on the last slot while holding; only the release brings it back to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                vec_mem[k] <= '0;
            end
        end else if (vec_release) begin
            idx <= '0;
        end else if (accept) begin
            vec_mem[idx] <= act;
            if (idx != LAST_IDX) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_pack
        assign out_data[k*OUT_W +: OUT_W] = vec_mem[k];
    end

`ifdef SAT_CNT_EN
    localparam int SAT_W = $clog2(NUM_OUT + 1);
    localparam logic [DATA_W-1:0] MAX_ACT = DATA_W'((1 << OUT_W) - 1);

    logic sat_hit;
    assign sat_hit = data_in[DATA_W-1] | (data_in > MAX_ACT);

    always_ff @(posedge clock) begin
        if (reset) begin
            sat_count <= '0;
        end else if (vec_release) begin
            sat_count <= '0;
        end else if (accept && sat_hit) begin
            sat_count <= sat_count + SAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_relu_collect.sv
// Self-checking bench for relu_collect: directed cases then randomized handshakes
// against a queue/array model of the collector.
module tb_relu_collect;

    localparam int NUM_OUT = 32;
    localparam int DATA_W  = 9;
    localparam int OUT_W   = 7;
    localparam int VEC_W   = NUM_OUT * OUT_W;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [DATA_W-1:0]  data_in;
    logic               in_ready;
    logic               out_valid;
    logic [VEC_W-1:0]   out_data;
    logic               out_ready;
`ifdef SAT_CNT_EN
    logic [$clog2(NUM_OUT+1)-1:0] sat_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int  m_fill;
    bit  m_hold;
    int  m_vec [NUM_OUT];
    int  m_sat;
    int  m_released;
    int  dut_released;

    relu_collect #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic int clip(input logic [DATA_W-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) return 0;
        if (v > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return v;
    endfunction

    function automatic logic [VEC_W-1:0] model_flat();
        logic [VEC_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_OUT; k++) f[k*OUT_W +: OUT_W] = OUT_W'(m_vec[k]);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
    endtask

    task automatic checkOutput();
        chk("in_ready", in_ready, !m_hold);
        chk("out_valid", out_valid, m_hold);
        if (m_hold) chk("out_data", out_data, model_flat());
`ifdef SAT_CNT_EN
        chk("sat_count", sat_count, m_sat);
`endif
    endtask

    // Model advances at the edge from the inputs presented during the cycle.
    task automatic modelEdge();
        int a;
        if (reset) begin
            m_fill = 0;
            m_hold = 0;
            m_sat  = 0;
            for (int k = 0; k < NUM_OUT; k++) m_vec[k] = 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                a = clip(data_in);
                m_vec[m_fill] = a;
                if (int'($signed(data_in)) < 0 || int'($signed(data_in)) > (1 << OUT_W) - 1) m_sat++;
                m_fill++;
                if (m_fill == NUM_OUT) m_hold = 1;
            end
        end else if (out_ready) begin
            m_hold = 0;
            m_fill = 0;
            m_sat  = 0;
            m_released++;
        end
    endtask

    task automatic step();
        checkOutput();
        if (out_valid && out_ready && !reset) dut_released++;
        @(posedge clock);
        modelEdge();
        #1;
    endtask

    initial begin
        logic [VEC_W-1:0] ramp;
        int cyc;
        int target;

        m_fill = 0; m_hold = 0; m_sat = 0; m_released = 0; dut_released = 0;
        for (int k = 0; k < NUM_OUT; k++) m_vec[k] = 0;
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        $display("[TB] reset state");
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
`ifdef SAT_CNT_EN
        chk("rst_sat_count", sat_count, 0);
`endif

        $display("[TB] ramp 0..31 back-to-back");
        for (int k = 0; k < NUM_OUT; k++) begin
            applyStimulus(1'b1, DATA_W'(k), 1'b0);
            step();
        end
        chk("ramp_valid_after_last", out_valid, 1'b1);
        ramp = '0;
        for (int k = 0; k < NUM_OUT; k++) ramp[k*OUT_W +: OUT_W] = OUT_W'(k);
        chk("ramp_elements", out_data, ramp);

        $display("[TB] hold with in_valid asserted");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, DATA_W'($urandom_range(0, 511)), 1'b0);
            step();
            chk("hold_stable", out_data, ramp);
        end
        applyStimulus(1'b0, '0, 1'b1);
        step();
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);

        $display("[TB] clip boundaries");
        applyStimulus(1'b1, 9'h1FB, 1'b0); step();
        applyStimulus(1'b1, 9'd200, 1'b0); step();
        applyStimulus(1'b1, 9'd127, 1'b0); step();
`ifdef SAT_CNT_EN
        chk("sat_two", sat_count, 2);
`endif
        for (int k = 3; k < NUM_OUT; k++) begin
            applyStimulus(1'b1, DATA_W'($urandom_range(0, 127)), 1'b0);
            step();
        end
        chk("clip_neg", out_data[0 +: OUT_W], 0);
        chk("clip_high", out_data[OUT_W +: OUT_W], 127);
        chk("clip_exact", out_data[2*OUT_W +: OUT_W], 127);
        applyStimulus(1'b0, '0, 1'b1);
        step();

        $display("[TB] reset mid-fill");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, DATA_W'($urandom_range(0, 511)), 1'b0);
            step();
        end
        reset = 1'b1;
        applyStimulus(1'b1, DATA_W'(9'd50), 1'b1);
        step();
        reset = 1'b0;
        chk("midfill_no_valid", out_valid, 1'b0);
        for (int k = 0; k < NUM_OUT; k++) begin
            applyStimulus(1'b1, DATA_W'(NUM_OUT - k), 1'b0);
            step();
        end
        chk("refill_elem0", out_data[0 +: OUT_W], NUM_OUT);
        chk("refill_elem31", out_data[31*OUT_W +: OUT_W], 1);
        applyStimulus(1'b0, '0, 1'b1);
        step();

        $display("[TB] random gaps over 100 vectors");
        target = m_released + 100;
        cyc = 0;
        while (m_released < target && cyc < 20000) begin
            applyStimulus($urandom_range(0, 9) < 7, DATA_W'($urandom_range(0, 511)),
                          $urandom_range(0, 1) == 1);
            step();
            cyc++;
        end
        chk("random_vectors_done", m_released, target);
        chk("random_release_count", dut_released, m_released);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/relu_collect.md
RELU_COLLECT -- requirements
Module: relu_collect

Interface
REQ-001 The parameter NUM_OUT SHALL default to 32 and SHALL set the number of neuron results collected per output vector.
REQ-002 The parameter DATA_W SHALL default to 9 and SHALL set the signed input width, matching the second-stage adder output.
REQ-003 The parameter OUT_W SHALL default to 7 and SHALL set the unsigned activation width.
REQ-004 The port list SHALL be exactly as follows:
  - clock  input  1  sole clock; all logic on the rising edge.
  - reset  input  1  synchronous, active-high reset.
  - in_valid  input  1  data_in is valid this cycle.
  - data_in  input  DATA_W  signed two's-complement neuron sum.
  - in_ready  output  1  the block accepts data_in this cycle.
  - out_valid  output  1  out_data holds a complete vector.
  - out_data  output  NUM_OUT*OUT_W  activations; element k is at bits [k*OUT_W +: OUT_W].
  - out_ready  input  1  the consumer takes out_data this cycle.
  - sat_count  output  $clog2(NUM_OUT+1)  clipped samples in the current vector; present only under SAT_CNT_EN.

Function
REQ-005 An input beat SHALL transfer only on a rising edge where in_valid=1 and in_ready=1.
REQ-006 Each accepted beat SHALL be transformed to an activation as follows:
  - negative (MSB=1) -> 0;
  - value > 2^OUT_W-1 -> 2^OUT_W-1 (127 by default);
  - otherwise the low OUT_W bits.
REQ-007 The block SHALL write beat number k (0-based, counted since the last vector release) into element k of the buffer.
REQ-008 The state machine SHALL have two states, FILL and HOLD; in FILL, in_ready=1 and out_valid=0.
REQ-009 Accepting beat NUM_OUT-1 in FILL SHALL move the FSM to HOLD on that edge, so out_valid=1 on the following cycle (1-cycle latency from the last beat).
REQ-010 In HOLD, in_ready SHALL be 0, and out_data and out_valid SHALL remain stable until out_ready=1.
REQ-011 An edge in HOLD with out_ready=1 SHALL return the FSM to FILL with the index cleared; in_ready SHALL rise on the next cycle, with no same-cycle bypass.
REQ-012 Buffer elements not yet rewritten SHALL keep their old values; out_data is defined only while out_valid=1.
REQ-013 in_valid=1 while in_ready=0 SHALL be ignored, with no state change.
REQ-014 The index counter SHALL wrap from NUM_OUT-1 to 0 only through the HOLD release; it SHALL never exceed NUM_OUT-1.

Reset
REQ-015 Reset SHALL set the FSM to FILL, the index to 0 and out_valid to 0, which makes in_ready=1 on the first cycle after reset.
REQ-016 Reset SHALL clear out_data to 0 and sat_count to 0.
REQ-017 Reset asserted mid-fill or during HOLD SHALL discard the partial or pending vector, and no out_valid SHALL follow from it.
REQ-018 Reset SHALL take priority over every simultaneous handshake.

Configuration
REQ-019 With SAT_CNT_EN defined, sat_count SHALL behave as follows:
  - increment on each accepted beat that is clipped high or negative;
  - hold during HOLD;
  - clear on the HOLD release edge.
REQ-020 Without SAT_CNT_EN, the sat_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-021 The shared package affine_pkg SHALL hold the DATA_W, OUT_W and NUM_OUT defaults and the FSM state enum (FILL, HOLD).
REQ-022 The clip of REQ-006 SHALL be a combinational sub-module named relu_sat, instantiated once.
REQ-023 The buffer SHALL be a single register array indexed by the write counter.

Verification
REQ-024 After reset: in_ready=1, out_valid=0, out_data=0, sat_count=0.
REQ-025 Feed 32 beats of values 0..31 back-to-back with out_ready=0: out_valid=1 exactly one cycle after beat 31; element k=k; in_ready=0 until release.
REQ-026 Beats -5 (0x1FB), 200 and 127 -> elements 0, 127 and 127; sat_count=2 under SAT_CNT_EN.
REQ-027 Hold out_ready=0 for 10 cycles while in_valid=1 in HOLD: out_data stable, no beats accepted; then out_ready=1 -> in_ready=1 next cycle and the index restarts at 0.
REQ-028 Assert reset after beat 15: no out_valid; the next 32 beats fill elements 0..31 normally.
REQ-029 Apply random in_valid/out_ready gaps over 100 vectors: each output vector equals the reference-model clip of its 32 accepted beats, in order.
